// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and reset/bubble defaults for the RV32I pipeline.
// No logic; constants and types only.
// No flow control; consumers decide how to use the bubble encoding.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;   // addi x0,x0,0

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        valid;
    } fetch_d_t;

endpackage

// File: rtl/fetch_stage_flopenrc.sv
// Parametric-width register with enable and synchronous clear to a fixed value.
// One cycle: d is visible on q after the next rising edge when enabled.
// Holds q when en is low; reset and clr both override en.
module flopenrc #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear has priority over enable so a squash is never lost to a hold
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses imem, registers the word into IF/ID.
// One cycle from pc_f to instr_d; a redirect reaches instr_d two cycles later.
// Stalls hold PC and/or IF/ID; imem not ready holds the PC and inserts bubbles.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pcsrc_e,
    input  logic [31:0] pctarget_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d
);

    // Reset PC is forced word-aligned so imem_addr can never be misaligned
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    localparam fetch_d_t BUBBLE = '{
        instr:   NOP_INSTR,
        pc:      32'h0,
        pcplus4: 32'h0,
        valid:   1'b0
    };

    logic [31:0] pcplus4_f;
    logic [31:0] pc_next;
    logic        pc_en;
    fetch_d_t    fetch_next;
    fetch_d_t    fetch_q;

    // Wraps modulo 2^32 by construction
    assign pcplus4_f = pc_f + 32'd4;

    // Next-PC select: a redirect beats both stall_f and a memory wait
    always_comb begin
        pc_next = pcplus4_f;
        pc_en   = 1'b0;
        if (pcsrc_e) begin
            pc_next = {pctarget_e[31:2], 2'b00};
            pc_en   = 1'b1;
        end else if (!stall_f && imem_ready) begin
            pc_en   = 1'b1;
        end
    end

    flopenrc #(
        .WIDTH   (32),
        .CLR_VAL (RESET_PC_ALIGNED)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .clr   (1'b0),
        .d     (pc_next),
        .q     (pc_f)
    );

    // IF/ID input: the fetched word when memory answered, otherwise a bubble
    always_comb begin
        fetch_next = BUBBLE;
        if (imem_ready) begin
            fetch_next.instr   = imem_rdata;
            fetch_next.pc      = pc_f;
            fetch_next.pcplus4 = pcplus4_f;
            fetch_next.valid   = 1'b1;
        end
    end

    // flush_d rides on the clear input so it wins over stall_d
    flopenrc #(
        .WIDTH   ($bits(fetch_d_t)),
        .CLR_VAL (BUBBLE)
    ) u_ifid_reg (
        .clk   (clk),
        .reset (reset),
        .en    (!stall_d),
        .clr   (flush_d),
        .d     (fetch_next),
        .q     (fetch_q)
    );

    assign imem_addr = pc_f;
    assign instr_d   = fetch_q.instr;
    assign pc_d      = fetch_q.pc;
    assign pcplus4_d = fetch_q.pcplus4;
    assign valid_d   = fetch_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns 0xA0 + (addr >> 2).
// Inputs change #1 after each rising edge, outputs are checked there too.
// Stalls, redirects, memory waits, priority collisions and PC wrap are covered.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pcsrc_e;
    logic [31:0] pctarget_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;

    int nvec = 0;
    int nerr = 0;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .pcsrc_e    (pcsrc_e),
        .pctarget_e (pctarget_e),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc_f       (pc_f),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory
    assign imem_rdata = 32'hA0 + (imem_addr >> 2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [31:0] e_pc_f, input logic [31:0] e_instr,
                         input logic [31:0] e_pc_d, input logic [31:0] e_p4, input logic e_vld);
        chk({tag, ".pc_f"}, pc_f, e_pc_f);
        chk({tag, ".imem_addr"}, imem_addr, e_pc_f);
        chk({tag, ".instr_d"}, instr_d, e_instr);
        chk({tag, ".pc_d"}, pc_d, e_pc_d);
        chk({tag, ".pcplus4_d"}, pcplus4_d, e_p4);
        chk({tag, ".valid_d"}, {31'b0, valid_d}, {31'b0, e_vld});
    endtask

    initial begin
        reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pcsrc_e = 1'b0; pctarget_e = 32'h0; imem_ready = 1'b1;
        step();
        step();
        chk_d("reset", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0);

        // Sequential fetch
        reset = 1'b0;
        step();
        chk_d("seq0", 32'h4, 32'hA0, 32'h0, 32'h4, 1'b1);
        step();
        chk_d("seq1", 32'h8, 32'hA1, 32'h4, 32'h8, 1'b1);

        // Full-stage freeze at pc_f = 8
        stall_f = 1'b1; stall_d = 1'b1;
        step();
        chk_d("stall0", 32'h8, 32'hA1, 32'h4, 32'h8, 1'b1);
        step();
        chk_d("stall1", 32'h8, 32'hA1, 32'h4, 32'h8, 1'b1);
        stall_f = 1'b0; stall_d = 1'b0;
        step();
        chk_d("unstall", 32'hC, 32'hA2, 32'h8, 32'hC, 1'b1);
        step();
        chk_d("seq3", 32'h10, 32'hA3, 32'hC, 32'h10, 1'b1);

        // Redirect to misaligned target, with flush
        pcsrc_e = 1'b1; pctarget_e = 32'h103; flush_d = 1'b1;
        step();
        chk_d("redir", 32'h100, 32'h13, 32'h0, 32'h0, 1'b0);
        pcsrc_e = 1'b0; flush_d = 1'b0;
        step();
        chk_d("redir_tgt", 32'h104, 32'hE0, 32'h100, 32'h104, 1'b1);

        // Move to 0x20, then memory wait for 3 cycles
        pcsrc_e = 1'b1; pctarget_e = 32'h20; flush_d = 1'b1;
        step();
        chk_d("to20", 32'h20, 32'h13, 32'h0, 32'h0, 1'b0);
        pcsrc_e = 1'b0; flush_d = 1'b0; imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_d("wait", 32'h20, 32'h13, 32'h0, 32'h0, 1'b0);
        end
        imem_ready = 1'b1;
        step();
        chk_d("ready", 32'h24, 32'hA8, 32'h20, 32'h24, 1'b1);

        // stall_f + pcsrc_e, and flush_d + stall_d, in the same cycle
        stall_f = 1'b1; stall_d = 1'b1; pcsrc_e = 1'b1; pctarget_e = 32'h40; flush_d = 1'b1;
        step();
        chk_d("prio", 32'h40, 32'h13, 32'h0, 32'h0, 1'b0);
        stall_f = 1'b0; stall_d = 1'b0; pcsrc_e = 1'b0; flush_d = 1'b0;
        step();
        chk_d("prio_tgt", 32'h44, 32'hB0, 32'h40, 32'h44, 1'b1);

        // Redirect while memory is not ready still moves the PC
        pcsrc_e = 1'b1; pctarget_e = 32'h80; imem_ready = 1'b0;
        step();
        chk_d("redir_nrdy", 32'h80, 32'h13, 32'h0, 32'h0, 1'b0);
        pcsrc_e = 1'b0; imem_ready = 1'b1;
        step();
        chk_d("redir_nrdy_tgt", 32'h84, 32'hC0, 32'h80, 32'h84, 1'b1);

        // Reset during a redirect with stall_d high
        reset = 1'b1; pcsrc_e = 1'b1; pctarget_e = 32'h200; stall_d = 1'b1; stall_f = 1'b1;
        step();
        chk_d("reset_mid", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0);
        reset = 1'b0; pcsrc_e = 1'b0; stall_d = 1'b0; stall_f = 1'b0;

        // Wrap-around from 0xFFFF_FFFC
        pcsrc_e = 1'b1; pctarget_e = 32'hFFFF_FFFC; flush_d = 1'b1;
        step();
        chk_d("wrap_redir", 32'hFFFF_FFFC, 32'h13, 32'h0, 32'h0, 1'b0);
        pcsrc_e = 1'b0; flush_d = 1'b0;
        step();
        chk_d("wrap", 32'h0, 32'h4000_009F, 32'hFFFF_FFFC, 32'h0, 1'b1);
        step();
        chk_d("wrap_next", 32'h4, 32'hA0, 32'h0, 32'h4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the program counter, drives the instruction-memory address and registers the fetched word into the IF/ID pipeline register. That register feeds the decode stage, where the immediate extender and control decoder consume `instr_d`. The block applies branch/jump redirects from Execute and stall/flush requests from the hazard unit, and inserts bubbles while instruction memory is not ready.

## Interface

Parameters:
- `RESET_PC` (default 32'h0000_0000): PC value loaded on reset.
- `NOP_INSTR` (default 32'h0000_0013, `addi x0,x0,0`): word placed in `instr_d` for a bubble.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `stall_f`, in, 1: hold the PC (hazard unit).
- `stall_d`, in, 1: hold the IF/ID register (hazard unit).
- `flush_d`, in, 1: squash the IF/ID register to a bubble.
- `pcsrc_e`, in, 1: taken branch or jump resolved in Execute.
- `pctarget_e`, in, 32: redirect target from Execute.
- `imem_addr`, out, 32: fetch address; equals `pc_f`.
- `imem_rdata`, in, 32: instruction word; combinational read of `imem_addr`.
- `imem_ready`, in, 1: `imem_rdata` is valid this cycle.
- `pc_f`, out, 32: current fetch PC.
- `instr_d`, out, 32: registered instruction to decode.
- `pc_d`, out, 32: PC of `instr_d`.
- `pcplus4_d`, out, 32: `pc_d + 4`.
- `valid_d`, out, 1: `instr_d` is a real instruction; 0 means bubble.

## Operation

PC next-state, highest priority first:
- `reset`: `RESET_PC`.
- `pcsrc_e`: `{pctarget_e[31:2], 2'b00}`. Redirect overrides both `stall_f` and `!imem_ready`.
- `stall_f`: hold.
- `!imem_ready`: hold (wait for memory).
- Otherwise: `pc_f + 4`, modulo 2^32. 32'hFFFF_FFFC wraps to 0.

IF/ID next-state, highest priority first:
- `reset` or `flush_d`: bubble, i.e. `instr_d=NOP_INSTR`, `valid_d=0`, `pc_d=0`, `pcplus4_d=0`.
- `stall_d`: hold all four fields.
- `imem_ready`: `instr_d=imem_rdata`, `pc_d=pc_f`, `pcplus4_d=pc_f+4`, `valid_d=1`.
- Otherwise: bubble.

Other rules:
- The block does not self-flush on `pcsrc_e`. The hazard unit must assert `flush_d` in the same cycle to kill the wrong-path word.
- `imem_addr` is always `pc_f` and is always word-aligned.
- There is no internal FSM beyond the PC and IF/ID registers. "Waiting" is simply `imem_ready=0` with the PC held.

## Timing

- Reset values: `pc_f = imem_addr = RESET_PC`, `instr_d = NOP_INSTR`, `pc_d = 0`, `pcplus4_d = 0`, `valid_d = 0`.
- Fetch latency: the word at `pc_f` in cycle N appears on `instr_d` in cycle N+1.
- Redirect: with `pcsrc_e` high in cycle N, `pc_f = target` in N+1 and the target instruction is on `instr_d` in N+2 (with `imem_ready` high).
- `stall_f` and `stall_d` together freeze the entire stage with no lost or duplicated instruction.
- `flush_d` and `stall_d` together: the flush wins and a bubble is loaded.
- Reset asserted mid-stream: the next edge yields the reset values regardless of every other input.
- `imem_ready` low for k cycles: k bubbles on `valid_d`, and the PC advances only on the first ready cycle.

## Structure

- Package `riscv_pkg` holds the `NOP_INSTR` and `RESET_PC` defaults plus a `fetch_d_t` packed struct of {instr, pc, pcplus4, valid}.
- Sub-module `flopenrc`: a parametric-width flop with enable and synchronous clear.
  - One instance for the PC, with clear value `RESET_PC`.
  - One instance for the IF/ID register (`fetch_d_t`), with clear value = bubble.
- The adder and next-PC mux stay inline.

## Test plan

- Reset, then memory always ready, returning 0xA0+i for the word at address 4i. Required: `instr_d` = 0xA0, 0xA1, 0xA2 with `pc_d` = 0, 4, 8, `pcplus4_d` = 4, 8, 12, and `valid_d = 1` from the 2nd cycle after reset.
- Stall: `stall_f` = `stall_d` = 1 for 2 cycles at `pc_f = 8`. Required: `pc_f` holds 8, `instr_d` holds the word from 4, and the next word delivered is from 8.
- Redirect: `pcsrc_e = 1`, `pctarget_e = 0x103`, `flush_d = 1`. Required: next `pc_f = 0x100` and `valid_d = 0`; the cycle after, `pc_d = 0x100` with `valid_d = 1`.
- Memory not ready: `imem_ready = 0` for 3 cycles at `pc_f = 0x20`. Required: 3 bubbles on `valid_d`, `pc_f` stays 0x20, then `pc_d = 0x20`.
- Priority collisions:
  - `stall_f` + `pcsrc_e`: the PC takes the target.
  - `flush_d` + `stall_d`: a bubble is loaded.
  - `reset` during a redirect: the PC goes to `RESET_PC`.
- Wrap-around: redirect to 0xFFFF_FFFC. Required: `pcplus4_d = 0` and the next `pc_f = 0`.
